cdc_handshake_rx: RTL and testbench

CDC_HANDSHAKE_RX -- requirements
Module: cdc_handshake_rx

---
 rtl/cdc_handshake_rx.sv | 114 +++++++++++
 tb/tb_cdc_handshake_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_rx.sv
// Receive side of a four-phase req/ack clock-domain crossing with a valid/ready output register.
// Optional sticky protocol checker enabled by defining CDC_HANDSHAKE_RX_PROTO_ERR_EN.
module cdc_handshake_rx #(
    parameter int DATA_W      = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clkB,
    input  logic              rst,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              proto_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_sync;
    logic [DATA_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   ack_q, ack_d;

    // Only the last synchronizer stage is safe to feed into logic.
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], req_in};
    assign req_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        unique case (state_q)
            IDLE: begin
                // data_in is only looked at on this capture edge.
                if (req_sync) begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_sync) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ack_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clkB or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sync_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
        end
    end

    assign ack_out   = ack_q;
    assign out_valid = valid_q;
    assign data_out  = data_q;

`ifdef CDC_HANDSHAKE_RX_PROTO_ERR_EN
    logic perr_q, perr_d;

    // Source withdrew req before the word was consumed; latch until reset.
    always_comb begin
        perr_d = perr_q;
        if (state_q == HOLD && !req_sync) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clkB or negedge rst) begin
        if (!rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign proto_err = perr_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Scoreboard bench for cdc_handshake_rx: directed timing checks plus randomized handshakes.
module tb_cdc_handshake_rx;

    localparam int DATA_W      = 2;
    localparam int SYNC_STAGES = 2;
`ifdef CDC_HANDSHAKE_RX_PROTO_ERR_EN
    localparam logic PERR_EN = 1'b1;
`else
    localparam logic PERR_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              out_ready;
    logic              proto_err;

    int checks = 0;
    int passed = 0;
    logic [DATA_W-1:0] exp_q[$];

    cdc_handshake_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clkB     (clk),
        .rst      (rst),
        .req_in   (req_in),
        .data_in  (data_in),
        .ack_out  (ack_out),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic expire(input string name);
        checks++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (ack_out !== lvl && n < 40) begin
            tick();
            n++;
        end
        if (ack_out !== lvl) expire(name);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (out_valid !== 1'b1) expire(name);
    endtask

    // Consumer-side monitor: every accepted word must match the oldest issued word.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL accept_unexpected: got %0h expected none", data_out);
            end else begin
                chk("accept_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    logic [DATA_W-1:0] words[20];

    initial begin
        int sent;
        int cyc;
        rst       = 1'b0;
        req_in    = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        #1;
        chk("rst_ack", 32'(ack_out), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_perr", 32'(proto_err), 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic transfer with consumer always ready.
        out_ready = 1'b1;
        data_in   = 2'b10;
        req_in    = 1'b1;
        exp_q.push_back(2'b10);
        tick();
        chk("lat_e1_valid", 32'(out_valid), 0);
        tick();
        chk("lat_e2_valid", 32'(out_valid), 0);
        tick();
        chk("lat_e3_valid", 32'(out_valid), 1);
        chk("lat_e3_data", 32'(data_out), 32'(2'b10));
        tick();
        chk("pulse_valid_low", 32'(out_valid), 0);
        chk("ack_rise", 32'(ack_out), 1);
        req_in = 1'b0;
        tick();
        chk("ack_fall_e1", 32'(ack_out), 1);
        tick();
        chk("ack_fall_e2", 32'(ack_out), 1);
        tick();
        chk("ack_fall_e3", 32'(ack_out), 0);

        // Consumer stalls for 10 cycles.
        out_ready = 1'b0;
        data_in   = 2'b01;
        req_in    = 1'b1;
        exp_q.push_back(2'b01);
        wait_valid("stall_valid");
        for (int i = 0; i < 10; i++) begin
            chk("stall_hold", {29'd0, out_valid, ack_out, data_out[0]} | 32'(data_out[1]) << 3,
                32'b0101);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("stall_release_ack", 32'(ack_out), 1);
        chk("stall_release_valid", 32'(out_valid), 0);
        req_in = 1'b0;
        wait_ack(1'b0, "stall_ack_fall");

        // Idle data_in wiggle must not reach data_out.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data_in = DATA_W'($urandom);
            tick();
            chk("idle_data_hold", 32'(data_out), 32'(2'b01));
        end
        chk("idle_valid", 32'(out_valid), 0);

        // req withdrawn while the word is still held.
        data_in = 2'b11;
        req_in  = 1'b1;
        exp_q.push_back(2'b11);
        wait_valid("perr_valid");
        req_in = 1'b0;
        tick();
        tick();
        tick();
        chk("perr_set", 32'(proto_err), 32'(PERR_EN));
        chk("perr_word_held", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        chk("perr_ack_rise", 32'(ack_out), 1);
        tick();
        chk("perr_ack_fall", 32'(ack_out), 0);
        tick();
        chk("perr_sticky", 32'(proto_err), 32'(PERR_EN));

        // Asynchronous reset while in ACK, req held high.
        data_in = 2'b11;
        req_in  = 1'b1;
        exp_q.push_back(2'b11);
        wait_ack(1'b1, "rst_mid_ack");
        #2 rst = 1'b0;
        #1;
        chk("arst_ack", 32'(ack_out), 0);
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_data", 32'(data_out), 0);
        chk("arst_perr", 32'(proto_err), 0);
        #2 rst = 1'b1;
        exp_q.push_back(2'b11);
        tick();
        chk("recap_e1_valid", 32'(out_valid), 0);
        tick();
        chk("recap_e2_valid", 32'(out_valid), 0);
        tick();
        chk("recap_e3_valid", 32'(out_valid), 1);
        chk("recap_e3_data", 32'(data_out), 32'(2'b11));
        req_in = 1'b0;
        wait_ack(1'b1, "recap_ack_rise");
        wait_ack(1'b0, "recap_ack_fall");

        // Randomized back-to-back handshakes with a random consumer.
        words[0] = 2'b00;
        words[1] = 2'b11;
        words[2] = 2'b01;
        words[3] = 2'b10;
        for (int i = 4; i < 20; i++) words[i] = DATA_W'($urandom);
        sent = 0;
        cyc  = 0;
        while (cyc < 3000) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!req_in && !ack_out && sent < 20 && $urandom_range(0, 3) != 0) begin
                data_in = words[sent];
                req_in  = 1'b1;
                exp_q.push_back(words[sent]);
                sent++;
            end else if (req_in && ack_out) begin
                req_in  = 1'b0;
                data_in = DATA_W'($urandom);
            end
            if (sent == 20 && !req_in && !ack_out && !out_valid && exp_q.size() == 0) break;
            tick();
            cyc++;
        end
        if (cyc >= 3000) expire("random_stream");
        chk("random_sent", 32'(sent), 20);
        tick();
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
